// File: rtl/regfile_xfer_sequencer.sv
// regfile_xfer_sequencer
//   Sequencer for LDM/STM-style multi-register transfers. It captures a
//   register list and a base address, then issues one register per cycle in
//   ascending order. Each beat carries a one-hot register address and a word
//   address. An optional base-writeback beat follows, then a done pulse.
//
// Optional feature: define REGSEQ_ABORT_EN to add the abort input and the
//   aborted output. The default build has no abort port, and every transfer
//   runs to completion.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   start       request pulse, sampled only in IDLE
//   reglist     register list (bit i = register i)
//   rn          base register index
//   base        base address
//   up/pre      ARM U/P addressing bits
//   wback       base writeback requested
//   load        1 = LDM, 0 = STM
//   stall       hold current beat (XFER/WB only)
//   busy        transfer in progress, through the done cycle
//   beat_valid  register beat presented: reg_onehot, mem_addr, beat_load, last
//   wb_valid    writeback beat presented: wb_onehot, wb_value
//   done        single-cycle completion pulse
//   abort       (REGSEQ_ABORT_EN) drop remaining beats and writeback
//   aborted     (REGSEQ_ABORT_EN) flags an aborted transfer during FIN
//
// state  | meaning
// -------+------------------------------------------------------
// S_IDLE | waiting for start
// S_XFER | presenting the lowest remaining register of the list
// S_WB   | presenting the base writeback beat
// S_FIN  | done pulse, then back to IDLE
module regfile_xfer_sequencer #(
  parameter int NREGS = 16,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NREGS-1:0] reglist,
  input  logic [3:0]       rn,
  input  logic [DW-1:0]    base,
  input  logic             up,
  input  logic             pre,
  input  logic             wback,
  input  logic             load,
  input  logic             stall,
`ifdef REGSEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             beat_valid,
  output logic [AW-1:0]    reg_onehot,
  output logic [DW-1:0]    mem_addr,
  output logic             beat_load,
  output logic             last,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_onehot,
  output logic [DW-1:0]    wb_value,
  output logic             done
);

  localparam int CW = $clog2(NREGS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wbval_q, wbval_d;
  logic [3:0]       rn_q, rn_d;
  logic             load_q, load_d;
  logic             wbdo_q, wbdo_d;
`ifdef REGSEQ_ABORT_EN
  logic             abt_q, abt_d;
`endif

  logic [CW-1:0]    n_regs;
  logic [DW-1:0]    n_bytes;
  logic [DW-1:0]    start_addr;
  logic [DW-1:0]    new_base;
  logic [NREGS-1:0] low_bit;
  logic             abort_hit;

  function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  always_comb begin
    n_regs  = popcount(reglist);
    n_bytes = DW'(n_regs) << 2;
    unique case ({up, pre})
      2'b10:   start_addr = base;
      2'b11:   start_addr = base + DW'(4);
      2'b00:   start_addr = base - n_bytes + DW'(4);
      default: start_addr = base - n_bytes;
    endcase
    new_base = up ? (base + n_bytes) : (base - n_bytes);
  end

  // Isolate the lowest set bit of the remaining list.
  assign low_bit = mask_q & (~mask_q + NREGS'(1));

`ifdef REGSEQ_ABORT_EN
  assign abort_hit = abort & ((state_q == S_XFER) | (state_q == S_WB));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbval_q <= '0;
      rn_q    <= '0;
      load_q  <= 1'b0;
      wbdo_q  <= 1'b0;
`ifdef REGSEQ_ABORT_EN
      abt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbval_q <= wbval_d;
      rn_q    <= rn_d;
      load_q  <= load_d;
      wbdo_q  <= wbdo_d;
`ifdef REGSEQ_ABORT_EN
      abt_q   <= abt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbval_d = wbval_q;
    rn_d    = rn_q;
    load_d  = load_q;
    wbdo_d  = wbdo_q;
`ifdef REGSEQ_ABORT_EN
    abt_d   = abt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = reglist;
          cnt_d   = n_regs;
          addr_d  = start_addr;
          wbval_d = new_base;
          rn_d    = rn;
          load_d  = load;
          // A loaded base register wins over the written-back base.
          wbdo_d  = wback & ~(load & reglist[rn]);
          if (n_regs != '0)                    state_d = S_XFER;
          else if (wback & ~(load & reglist[rn])) state_d = S_WB;
          else                                 state_d = S_FIN;
        end
      end
      S_XFER: begin
        if (abort_hit) begin
          state_d = S_FIN;
`ifdef REGSEQ_ABORT_EN
          abt_d   = 1'b1;
`endif
        end else if (!stall) begin
          mask_d = mask_q & (mask_q - NREGS'(1));
          cnt_d  = cnt_q - CW'(1);
          addr_d = addr_q + DW'(4);
          if (cnt_q == CW'(1)) state_d = wbdo_q ? S_WB : S_FIN;
        end
      end
      S_WB: begin
        if (abort_hit) begin
          state_d = S_FIN;
`ifdef REGSEQ_ABORT_EN
          abt_d   = 1'b1;
`endif
        end else if (!stall) begin
          state_d = S_FIN;
        end
      end
      default: begin
        state_d = S_IDLE;
`ifdef REGSEQ_ABORT_EN
        abt_d   = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    beat_valid = (state_q == S_XFER);
    reg_onehot = beat_valid ? AW'(low_bit) : '0;
    mem_addr   = beat_valid ? addr_q : '0;
    beat_load  = beat_valid & load_q;
    last       = beat_valid & (cnt_q == CW'(1));
    wb_valid   = (state_q == S_WB);
    wb_onehot  = wb_valid ? (AW'(1) << rn_q) : '0;
    wb_value   = wb_valid ? wbval_q : '0;
    done       = (state_q == S_FIN);
`ifdef REGSEQ_ABORT_EN
    aborted    = abt_q;
`endif
  end

endmodule

// File: doc/regfile_xfer_sequencer.md
Name: regfile_xfer_sequencer

Overview:
- Sequencer for LDM/STM-style multi-register transfers in the decode/execute path.
- Accepts a 16-bit register list and base address. Issues one register per cycle in ascending order, each as a one-hot register address plus memory address. This is the form the register file's one-hot read/write ports consume.
- Finishes with an optional base-writeback beat, then a done pulse.
- Initiator side of the one-hot register-file port protocol.

Parameters:
- NREGS, 16, width of the register list; bit i selects register i.
- AW, 32, width of the one-hot register address outputs; matches the register file port width.
- DW, 32, address/data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting 0 clears all state immediately.
- start  input  1  request pulse; sampled only in IDLE.
- reglist  input  NREGS  register list, captured on accepted start.
- rn  input  4  base register index, captured on start.
- base  input  DW  base address value, captured on start.
- up  input  1  1 = increment, 0 = decrement (ARM U bit).
- pre  input  1  1 = before, 0 = after (ARM P bit).
- wback  input  1  base writeback requested (ARM W bit).
- load  input  1  1 = LDM, 0 = STM.
- stall  input  1  hold current beat; no state advance.
- busy  output  1  high from accepted start until done cycle inclusive.
- beat_valid  output  1  a register transfer beat is presented.
- reg_onehot  output  AW  one-hot register address of current beat (bits AW-1..NREGS always 0).
- mem_addr  output  DW  word address of current beat.
- beat_load  output  1  copy of captured load for current beat.
- last  output  1  current beat is the final register beat.
- wb_valid  output  1  writeback beat presented.
- wb_onehot  output  AW  one-hot of captured rn during writeback beat.
- wb_value  output  DW  new base value during writeback beat.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, captured registers 0.
- States and transitions:
  - IDLE: start=1 captures all inputs, computes n = popcount(reglist) and moves to XFER. If n=0, goes instead to WB (wback=1) or FIN (wback=0).
  - XFER: presents the lowest remaining set bit each cycle. If stall=0: clear that bit, mem_addr += 4. After the beat with last=1, go to WB or FIN.
  - WB: wb_valid=1 for one cycle (held while stall). Then FIN.
  - FIN: done=1, busy=1 for one cycle, then IDLE.
- Start address, computed at capture:
  - up&~pre = base
  - up&pre = base+4
  - ~up&~pre = base-4n+4
  - ~up&pre = base-4n
- Register order is always ascending with address ascending, regardless of up.
- Writeback value: up ? base+4n : base-4n, modulo 2^DW.
- Empty list (n=0): no beats; wb_value = base.
- Writeback suppression: load=1 and reglist[rn]=1 suppresses the writeback beat (loaded value wins); go directly to FIN.
- Address arithmetic wraps modulo 2^DW; no error is flagged.
- Latency: first beat one cycle after accepted start. Total cycles = 1 + n + wb + 1, excluding stall cycles.
- stall: all outputs and state held unchanged while stall=1 in XFER/WB. stall is ignored in IDLE and FIN.
- start while busy: ignored, with no queueing.
- reset asserted mid-transfer: immediate return to IDLE. No done pulse and no writeback.
- beat_valid, wb_valid and done are mutually exclusive.

Optional Feature:
- Macro REGSEQ_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in XFER or WB has priority over stall. Next cycle is FIN with done=1 and aborted=1.
  - Remaining beats and writeback are dropped.
  - aborted clears on return to IDLE.
- Not defined: no abort port exists; every transfer runs to completion.

Test Plan:
- STM up/after: reglist=0x0013, base=0x1000, rn=13, wback=1, load=0 -> beats r0@0x1000, r1@0x1004, r4@0x1008 (last on r4); then wb_onehot=1<<13, wb_value=0x100C; done on cycle 6.
- LDM down/before: reglist=0x8003, base=0x2000, pre=1, up=0 -> r0@0x1FF4, r1@0x1FF8, r15@0x1FFC; wback=0, so no wb beat; done follows last.
- Empty list with wback=1, base=0x40 -> no beat_valid; wb_value=0x40; done on cycle 3.
- LDM with rn=2, reglist=0x0004, wback=1 -> single beat r2@base; wb_valid never asserted; done after beat.
- stall held 3 cycles during second beat of 0x0006 -> reg_onehot=0x4 and mem_addr held stable for all 3 stalled cycles; sequence otherwise unchanged. A start pulse issued mid-transfer is ignored.
- reset driven low during first beat -> all outputs 0 immediately; after release, a new start (reglist=0x0001) runs normally.
